// File: rtl/riscv_pipe_pkg.sv
// Shared encodings for the RISC-V pipeline: opcodes, result/ALU/immediate
// select codes and the decoded control bundle carried through ID/EX.
package riscv_pipe_pkg;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_LUI = 7'b0110111;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10
    } result_src_e;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_SLT = 3'b101
    } alu_ctrl_e;

    // IMM_NONE marks instructions with no immediate; it yields a zero extension.
    typedef enum logic [2:0] {
        IMM_I    = 3'b000,
        IMM_S    = 3'b001,
        IMM_B    = 3'b010,
        IMM_J    = 3'b011,
        IMM_U    = 3'b100,
        IMM_NONE = 3'b111
    } imm_src_e;

    typedef struct packed {
        logic       reg_write;
        logic       alu_src;
        logic       mem_write;
        logic       branch;
        logic       jump;
        logic [1:0] result_src;
        logic [2:0] alu_control;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 3'b000};

    // Subtract is only honoured where the caller allows it (R-type).
    function automatic logic [2:0] alu_decode(input logic [2:0] funct3, input logic sub_en);
        logic [2:0] op;
        case (funct3)
            3'b000:  op = sub_en ? ALU_SUB : ALU_ADD;
            3'b010:  op = ALU_SLT;
            3'b110:  op = ALU_OR;
            3'b111:  op = ALU_AND;
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/decode_ctrl.sv
// Main decoder: opcode/funct3/funct7[5] -> control signals, ALU operation
// and immediate format select.
module decode_ctrl
    import riscv_pipe_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    output logic       reg_write,
    output logic       alu_src,
    output logic       mem_write,
    output logic       branch,
    output logic       jump,
    output logic [1:0] result_src,
    output logic [2:0] alu_control,
    output logic [2:0] imm_src
);

    // Opcode decode; unknown opcodes fall through with everything inactive.
    always_comb begin
        reg_write   = 1'b0;
        alu_src     = 1'b0;
        mem_write   = 1'b0;
        branch      = 1'b0;
        jump        = 1'b0;
        result_src  = RES_ALU;
        alu_control = ALU_ADD;
        imm_src     = IMM_NONE;
        case (opcode)
            OP_LW: begin
                reg_write  = 1'b1;
                alu_src    = 1'b1;
                result_src = RES_MEM;
                imm_src    = IMM_I;
            end
            OP_SW: begin
                alu_src   = 1'b1;
                mem_write = 1'b1;
                imm_src   = IMM_S;
            end
            OP_R: begin
                reg_write   = 1'b1;
                alu_control = alu_decode(funct3, funct7_5);
            end
            OP_I: begin
                reg_write   = 1'b1;
                alu_src     = 1'b1;
                alu_control = alu_decode(funct3, 1'b0);
                imm_src     = IMM_I;
            end
            OP_BEQ: begin
                branch      = 1'b1;
                alu_control = ALU_SUB;
                imm_src     = IMM_B;
            end
            OP_JAL: begin
                reg_write  = 1'b1;
                jump       = 1'b1;
                result_src = RES_PC4;
                imm_src    = IMM_J;
            end
            OP_LUI: begin
                reg_write = 1'b1;
                alu_src   = 1'b1;
                imm_src   = IMM_U;
            end
            default: begin
                reg_write = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/decode_pipe_stage.sv
// Decode stage: register file with write-through bypass, immediate generator,
// control decode and the ID/EX pipeline register.
module decode_pipe_stage
    import riscv_pipe_pkg::*;
#(
    parameter  int XLEN = 32,
    parameter  int NREG = 32,
    localparam int AW   = $clog2(NREG)
)
(
    input  logic            clk,
    input  logic            rst,
    input  logic            StallD,
    input  logic            FlushE,
    input  logic            ValidD,
    input  logic            RegWriteW,
    input  logic [AW-1:0]   RDW,
    input  logic [XLEN-1:0] ResultW,
    input  logic [31:0]     InstrD,
    input  logic [XLEN-1:0] PCD,
    input  logic [XLEN-1:0] PCPlus4D,
    output logic            RegWriteE,
    output logic            ALUSrcE,
    output logic            MemWriteE,
    output logic            BranchE,
    output logic            JumpE,
    output logic            ValidE,
    output logic [1:0]      ResultSrcE,
    output logic [2:0]      ALUControlE,
    output logic [XLEN-1:0] RD1_E,
    output logic [XLEN-1:0] RD2_E,
    output logic [XLEN-1:0] Imm_Ext_E,
    output logic [XLEN-1:0] PCE,
    output logic [XLEN-1:0] PCPlus4E,
    output logic [AW-1:0]   RS1_E,
    output logic [AW-1:0]   RS2_E,
    output logic [AW-1:0]   RD_E,
    output logic [AW-1:0]   RS1_D,
    output logic [AW-1:0]   RS2_D
);

    logic            dec_reg_write_s;
    logic            dec_alu_src_s;
    logic            dec_mem_write_s;
    logic            dec_branch_s;
    logic            dec_jump_s;
    logic [1:0]      dec_result_src_s;
    logic [2:0]      dec_alu_control_s;
    logic [2:0]      imm_src_s;
    ctrl_t           ctrl_s;

    logic [AW-1:0]   rs1_s;
    logic [AW-1:0]   rs2_s;
    logic [AW-1:0]   rd_s;
    logic [XLEN-1:0] rd1_s;
    logic [XLEN-1:0] rd2_s;
    logic [31:0]     imm32_s;
    logic [XLEN-1:0] imm_ext_s;

    logic [XLEN-1:0] regs_r [NREG];

    ctrl_t           ctrl_e_r;
    logic            valid_e_r;
    logic [XLEN-1:0] rd1_e_r;
    logic [XLEN-1:0] rd2_e_r;
    logic [XLEN-1:0] imm_e_r;
    logic [XLEN-1:0] pc_e_r;
    logic [XLEN-1:0] pc4_e_r;
    logic [AW-1:0]   rs1_e_r;
    logic [AW-1:0]   rs2_e_r;
    logic [AW-1:0]   rd_e_r;

    decode_ctrl u_decode_ctrl (
        .opcode      (InstrD[6:0]),
        .funct3      (InstrD[14:12]),
        .funct7_5    (InstrD[30]),
        .reg_write   (dec_reg_write_s),
        .alu_src     (dec_alu_src_s),
        .mem_write   (dec_mem_write_s),
        .branch      (dec_branch_s),
        .jump        (dec_jump_s),
        .result_src  (dec_result_src_s),
        .alu_control (dec_alu_control_s),
        .imm_src     (imm_src_s)
    );

    assign rs1_s = InstrD[15 +: AW];
    assign rs2_s = InstrD[20 +: AW];
    assign rd_s  = InstrD[7 +: AW];
    assign RS1_D = rs1_s;
    assign RS2_D = rs2_s;

    // Bundle the decoder outputs for the pipeline register.
    always_comb begin
        ctrl_s             = CTRL_NOP;
        ctrl_s.reg_write   = dec_reg_write_s;
        ctrl_s.alu_src     = dec_alu_src_s;
        ctrl_s.mem_write   = dec_mem_write_s;
        ctrl_s.branch      = dec_branch_s;
        ctrl_s.jump        = dec_jump_s;
        ctrl_s.result_src  = dec_result_src_s;
        ctrl_s.alu_control = dec_alu_control_s;
    end

    // Immediate generator; formats are assembled at 32 bits then sign-extended.
    always_comb begin
        imm32_s = 32'h0000_0000;
        case (imm_src_s)
            IMM_I:   imm32_s = {{20{InstrD[31]}}, InstrD[31:20]};
            IMM_S:   imm32_s = {{20{InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
            IMM_B:   imm32_s = {{19{InstrD[31]}}, InstrD[31], InstrD[7],
                                InstrD[30:25], InstrD[11:8], 1'b0};
            IMM_J:   imm32_s = {{11{InstrD[31]}}, InstrD[31], InstrD[19:12],
                                InstrD[20], InstrD[30:21], 1'b0};
            IMM_U:   imm32_s = {InstrD[31:12], 12'h000};
            default: imm32_s = 32'h0000_0000;
        endcase
        imm_ext_s = XLEN'($signed(imm32_s));
    end

    // Register file storage; x0 is never written.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_r[i] <= '0;
            end
        end else if (RegWriteW && (RDW != '0)) begin
            regs_r[RDW] <= ResultW;
        end
    end

    // Read ports: x0 reads zero, a same-cycle write to the source is forwarded.
    always_comb begin
        rd1_s = '0;
        rd2_s = '0;
        if (rs1_s == '0) begin
            rd1_s = '0;
        end else if (RegWriteW && (RDW == rs1_s)) begin
            rd1_s = ResultW;
        end else begin
            rd1_s = regs_r[rs1_s];
        end
        if (rs2_s == '0) begin
            rd2_s = '0;
        end else if (RegWriteW && (RDW == rs2_s)) begin
            rd2_s = ResultW;
        end else begin
            rd2_s = regs_r[rs2_s];
        end
    end

    // ID/EX register: flush beats stall beats load; invalid slots carry no control.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ctrl_e_r  <= CTRL_NOP;
            valid_e_r <= 1'b0;
            rd1_e_r   <= '0;
            rd2_e_r   <= '0;
            imm_e_r   <= '0;
            pc_e_r    <= '0;
            pc4_e_r   <= '0;
            rs1_e_r   <= '0;
            rs2_e_r   <= '0;
            rd_e_r    <= '0;
        end else if (FlushE) begin
            ctrl_e_r  <= CTRL_NOP;
            valid_e_r <= 1'b0;
            rd1_e_r   <= '0;
            rd2_e_r   <= '0;
            imm_e_r   <= '0;
            pc_e_r    <= '0;
            pc4_e_r   <= '0;
            rs1_e_r   <= '0;
            rs2_e_r   <= '0;
            rd_e_r    <= '0;
        end else if (!StallD) begin
            ctrl_e_r  <= ValidD ? ctrl_s : CTRL_NOP;
            valid_e_r <= ValidD;
            rd1_e_r   <= rd1_s;
            rd2_e_r   <= rd2_s;
            imm_e_r   <= imm_ext_s;
            pc_e_r    <= PCD;
            pc4_e_r   <= PCPlus4D;
            rs1_e_r   <= rs1_s;
            rs2_e_r   <= rs2_s;
            rd_e_r    <= rd_s;
        end
    end

    assign RegWriteE   = ctrl_e_r.reg_write;
    assign ALUSrcE     = ctrl_e_r.alu_src;
    assign MemWriteE   = ctrl_e_r.mem_write;
    assign BranchE     = ctrl_e_r.branch;
    assign JumpE       = ctrl_e_r.jump;
    assign ResultSrcE  = ctrl_e_r.result_src;
    assign ALUControlE = ctrl_e_r.alu_control;
    assign ValidE      = valid_e_r;
    assign RD1_E       = rd1_e_r;
    assign RD2_E       = rd2_e_r;
    assign Imm_Ext_E   = imm_e_r;
    assign PCE         = pc_e_r;
    assign PCPlus4E    = pc4_e_r;
    assign RS1_E       = rs1_e_r;
    assign RS2_E       = rs2_e_r;
    assign RD_E        = rd_e_r;

endmodule

// File: tb/tb_decode_pipe_stage.sv
// Bench for decode_pipe_stage: directed scenarios with literal expectations,
// then randomized traffic against an instruction-level reference model.
module tb_decode_pipe_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        StallD, FlushE, ValidD, RegWriteW;
    logic [4:0]  RDW;
    logic [31:0] ResultW, InstrD, PCD, PCPlus4D;
    logic        RegWriteE, ALUSrcE, MemWriteE, BranchE, JumpE, ValidE;
    logic [1:0]  ResultSrcE;
    logic [2:0]  ALUControlE;
    logic [31:0] RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E;
    logic [4:0]  RS1_E, RS2_E, RD_E, RS1_D, RS2_D;

    int total = 0;
    int bad   = 0;

    decode_pipe_stage #(.XLEN(32), .NREG(32)) dut (
        .clk(clk), .rst(rst), .StallD(StallD), .FlushE(FlushE), .ValidD(ValidD),
        .RegWriteW(RegWriteW), .RDW(RDW), .ResultW(ResultW), .InstrD(InstrD),
        .PCD(PCD), .PCPlus4D(PCPlus4D),
        .RegWriteE(RegWriteE), .ALUSrcE(ALUSrcE), .MemWriteE(MemWriteE),
        .BranchE(BranchE), .JumpE(JumpE), .ValidE(ValidE),
        .ResultSrcE(ResultSrcE), .ALUControlE(ALUControlE),
        .RD1_E(RD1_E), .RD2_E(RD2_E), .Imm_Ext_E(Imm_Ext_E), .PCE(PCE),
        .PCPlus4E(PCPlus4E), .RS1_E(RS1_E), .RS2_E(RS2_E), .RD_E(RD_E),
        .RS1_D(RS1_D), .RS2_D(RS2_D)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference: {RegWrite, ALUSrc, MemWrite, Branch, Jump, ResultSrc[1:0], ALUControl[2:0]}
    function automatic logic [9:0] model_ctrl(input logic [31:0] ins);
        logic [2:0] alu;
        logic [2:0] f3;
        f3 = ins[14:12];
        alu = (f3 == 3'd2) ? 3'b101 : (f3 == 3'd6) ? 3'b011 : (f3 == 3'd7) ? 3'b010 : 3'b000;
        case (ins[6:0])
            7'b0000011: return {5'b11000, 2'b01, 3'b000};
            7'b0100011: return {5'b01100, 2'b00, 3'b000};
            7'b0110011: return {5'b10000, 2'b00,
                                (f3 == 3'd0 && ins[30]) ? 3'b001 : alu};
            7'b0010011: return {5'b11000, 2'b00, alu};
            7'b1100011: return {5'b00010, 2'b00, 3'b001};
            7'b1101111: return {5'b10001, 2'b10, 3'b000};
            7'b0110111: return {5'b11000, 2'b00, 3'b000};
            default:    return 10'd0;
        endcase
    endfunction

    function automatic logic [31:0] model_imm(input logic [31:0] i);
        case (i[6:0])
            7'b0000011, 7'b0010011: return {{20{i[31]}}, i[31:20]};
            7'b0100011: return {{20{i[31]}}, i[31:25], i[11:7]};
            7'b1100011: return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            7'b1101111: return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            7'b0110111: return {i[31:12], 12'h000};
            default:    return 32'd0;
        endcase
    endfunction

    // Model state: architectural registers plus expected E outputs.
    logic [31:0] mregs [32];
    logic [10:0] m_ctrl = 11'd0;
    logic [31:0] m_rd1 = 32'd0, m_rd2 = 32'd0, m_imm = 32'd0, m_pc = 32'd0, m_pc4 = 32'd0;
    logic [4:0]  m_rs1 = 5'd0, m_rs2 = 5'd0, m_rd = 5'd0;

    function automatic logic [31:0] mread(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (RegWriteW && RDW == a) return ResultW;
        return mregs[a];
    endfunction

    task automatic mclear_e();
        m_ctrl = 11'd0; m_rd1 = 32'd0; m_rd2 = 32'd0; m_imm = 32'd0;
        m_pc = 32'd0; m_pc4 = 32'd0; m_rs1 = 5'd0; m_rs2 = 5'd0; m_rd = 5'd0;
    endtask

    always @(posedge clk or negedge rst) begin
        logic [9:0] c;
        if (!rst) begin
            mclear_e();
            for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
        end else begin
            if (FlushE) begin
                mclear_e();
            end else if (!StallD) begin
                c = model_ctrl(InstrD);
                m_ctrl = ValidD ? {c[9:5], 1'b1, c[4:0]} : 11'd0;
                m_rd1 = mread(InstrD[19:15]);
                m_rd2 = mread(InstrD[24:20]);
                m_imm = model_imm(InstrD);
                m_pc = PCD; m_pc4 = PCPlus4D;
                m_rs1 = InstrD[19:15]; m_rs2 = InstrD[24:20]; m_rd = InstrD[11:7];
            end
            if (RegWriteW && RDW != 5'd0) mregs[RDW] = ResultW;
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        chk("ctrl", {RegWriteE, ALUSrcE, MemWriteE, BranchE, JumpE, ValidE,
                     ResultSrcE, ALUControlE}, m_ctrl);
        chk("rd1", RD1_E, m_rd1);
        chk("rd2", RD2_E, m_rd2);
        chk("imm", Imm_Ext_E, m_imm);
        chk("pc", {PCE, PCPlus4E}, {m_pc, m_pc4});
        chk("regidx", {RS1_E, RS2_E, RD_E}, {m_rs1, m_rs2, m_rd});
        chk("rs_d", {RS1_D, RS2_D}, {InstrD[19:15], InstrD[24:20]});
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] ins, input logic [31:0] pc, input logic v);
        InstrD = ins; PCD = pc; PCPlus4D = pc + 32'd4; ValidD = v;
    endtask

    logic [31:0] r;
    logic [6:0]  ops [8];

    initial begin
        rst = 1'b0; StallD = 1'b0; FlushE = 1'b0; ValidD = 1'b0; RegWriteW = 1'b0;
        RDW = 5'd0; ResultW = 32'd0; InstrD = 32'd0; PCD = 32'd0; PCPlus4D = 32'd0;
        repeat (2) tick();
        chk("reset_valid", ValidE, 1'b0);
        chk("reset_regwrite", RegWriteE, 1'b0);
        chk("reset_pce", PCE, 32'd0);
        #3 rst = 1'b1;
        tick();

        // Bypass: write x5 while add x6,x5,x0 reads it.
        RegWriteW = 1'b1; RDW = 5'd5; ResultW = 32'h0000_00AA;
        drive({7'd0, 5'd0, 5'd5, 3'd0, 5'd6, 7'b0110011}, 32'h10, 1'b1);
        tick();
        chk("bypass_rd1", RD1_E, 32'h0000_00AA);
        chk("bypass_rd", RD_E, 5'd6);

        // x0 protection.
        RDW = 5'd0; ResultW = 32'hFFFF_FFFF;
        drive({7'd0, 5'd0, 5'd0, 3'd0, 5'd7, 7'b0110011}, 32'h14, 1'b1);
        tick();
        RegWriteW = 1'b0;
        chk("x0_bypass", RD1_E, 32'd0);
        drive({7'd0, 5'd5, 5'd0, 3'd0, 5'd7, 7'b0110011}, 32'h18, 1'b1);
        tick();
        chk("x0_read", RD1_E, 32'd0);
        chk("x5_stored", RD2_E, 32'h0000_00AA);

        // Immediates: lui x1,0x12345 then jal x1,-4.
        drive({20'h12345, 5'd1, 7'b0110111}, 32'h1C, 1'b1);
        tick();
        chk("lui_imm", Imm_Ext_E, 32'h1234_5000);
        drive({1'b1, 10'h3FE, 1'b1, 8'hFF, 5'd1, 7'b1101111}, 32'h20, 1'b1);
        tick();
        chk("jal_imm", Imm_Ext_E, 32'hFFFF_FFFC);
        chk("jal_jump", JumpE, 1'b1);
        chk("jal_ressrc", ResultSrcE, 2'b10);

        // Stall freezes E, flush wins over stall.
        drive({12'd8, 5'd5, 3'b010, 5'd3, 7'b0000011}, 32'h100, 1'b1);
        tick();
        chk("lw_pce", PCE, 32'h100);
        StallD = 1'b1;
        drive({7'd0, 5'd5, 5'd6, 3'b010, 5'd4, 7'b0100011}, 32'h200, 1'b1);
        tick();
        tick();
        chk("stall_pce", PCE, 32'h100);
        chk("stall_regwrite", RegWriteE, 1'b1);
        chk("stall_rd1", RD1_E, 32'h0000_00AA);
        FlushE = 1'b1;
        tick();
        chk("flush_regwrite", RegWriteE, 1'b0);
        chk("flush_valid", ValidE, 1'b0);
        chk("flush_pce", PCE, 32'd0);
        FlushE = 1'b0; StallD = 1'b0;

        // Invalid slot: sw with ValidD=0 keeps data, drops control.
        drive({7'd0, 5'd5, 5'd6, 3'b010, 5'd4, 7'b0100011}, 32'h300, 1'b0);
        tick();
        chk("inv_memwrite", MemWriteE, 1'b0);
        chk("inv_valid", ValidE, 1'b0);
        chk("inv_pce", PCE, 32'h300);
        chk("inv_imm", Imm_Ext_E, 32'd4);

        // Asynchronous reset mid-stall with a valid instruction held.
        drive({7'd0, 5'd0, 5'd5, 3'd0, 5'd6, 7'b0110011}, 32'h400, 1'b1);
        tick();
        chk("pre_rst_valid", ValidE, 1'b1);
        StallD = 1'b1;
        #2 rst = 1'b0;
        #1;
        chk("arst_valid", ValidE, 1'b0);
        chk("arst_regwrite", RegWriteE, 1'b0);
        chk("arst_pce", PCE, 32'd0);
        chk("arst_rd1", RD1_E, 32'd0);
        @(posedge clk);
        #3 rst = 1'b1;
        StallD = 1'b0;
        tick();
        chk("post_rst_x5", RD1_E, 32'd0);
        chk("post_rst_pce", PCE, 32'h400);
        chk("post_rst_valid", ValidE, 1'b1);

        // Randomized traffic.
        ops[0] = 7'b0000011; ops[1] = 7'b0100011; ops[2] = 7'b0110011; ops[3] = 7'b0010011;
        ops[4] = 7'b1100011; ops[5] = 7'b1101111; ops[6] = 7'b0110111; ops[7] = 7'b1010101;
        for (int n = 0; n < 3000; n++) begin
            r = $urandom();
            InstrD = {r[31:7], ops[$urandom_range(7)]};
            r = $urandom();
            PCD = r; PCPlus4D = r + 32'd4;
            ValidD = ($urandom_range(7) != 0);
            StallD = ($urandom_range(7) == 0);
            FlushE = ($urandom_range(9) == 0);
            RegWriteW = $urandom_range(1);
            RDW = ($urandom_range(3) == 0) ? InstrD[19:15] : 5'($urandom_range(31));
            ResultW = $urandom();
            if ($urandom_range(199) == 0) begin
                #2 rst = 1'b0;
                #3 rst = 1'b1;
            end
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/decode_pipe_stage.md
DECODE_PIPE_STAGE -- requirements
Module: decode_pipe_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width.
REQ-002 SHALL have parameter NREG, default 32, architectural register count; AW = clog2(NREG).
REQ-003 SHALL have ports clk (input, 1, clock) and rst (input, 1, reset): asynchronous, active-low.
REQ-004 SHALL have input ports: StallD (1, hold ID/EX), FlushE (1, bubble into ID/EX), ValidD (1, InstrD valid), RegWriteW (1), RDW (AW), ResultW (XLEN), InstrD (32), PCD (XLEN), PCPlus4D (XLEN).
REQ-005 SHALL have output ports: RegWriteE, ALUSrcE, MemWriteE, BranchE, JumpE, ValidE (1 each); ResultSrcE (2); ALUControlE (3).
REQ-006 SHALL have output ports: RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E (XLEN each); RS1_E, RS2_E, RD_E (AW each); RS1_D, RS2_D (AW each, combinational, for hazard unit).

Function
REQ-007 SHALL decode opcodes: lw 0000011, sw 0100011, R 0110011, I-ALU 0010011, beq 1100011, jal 1101111, lui 0110111; any other opcode gives all control 0 and Imm_Ext 0.
REQ-008 SHALL encode ResultSrc as 00 ALU, 01 memory, 10 PC+4.
REQ-009 SHALL encode ALUControl as 000 add, 001 sub, 010 and, 011 or, 101 slt.
REQ-010 SHALL select sub when funct7[5]=1 on R-type only.
REQ-011 SHALL produce sign-extended immediates: I, S, B (bit0=0), J (bit0=0), and U (InstrD[31:12] followed by 12 zeros).
REQ-012 SHALL treat register 0 as always zero.
REQ-013 SHALL write the register file at posedge clk when RegWriteW=1 and RDW!=0.
REQ-014 SHALL bypass writes to same-cycle reads: a read where RegWriteW=1 and RDW equals a nonzero source address returns ResultW.
REQ-015 SHALL update the ID/EX register at posedge clk with priority FlushE > StallD > load.
REQ-016 SHALL, on FlushE=1, clear every E output (including ValidE) to 0, regardless of StallD.
REQ-017 SHALL, on StallD=1 with FlushE=0, hold all E outputs unchanged.
REQ-018 SHALL, on load with ValidD=0, capture all control bits and ValidE as 0 while still capturing data fields.
REQ-019 SHALL give one-cycle latency InstrD -> E outputs.
REQ-020 SHALL drive RS1_D = InstrD[15+:AW] and RS2_D = InstrD[20+:AW] combinationally, independent of ValidD.

Reset
REQ-021 SHALL, while rst=0, clear all ID/EX fields and every E output to 0 immediately, without waiting for a clock edge.
REQ-022 SHALL, while rst=0, clear all register-file entries to 0.
REQ-023 SHALL give rst priority over FlushE, StallD and writes, including reset asserted mid-stall.
REQ-024 SHALL resume normal loading at the first posedge clk after rst deasserts.

Structure
REQ-025 SHALL place opcode constants, ResultSrc codes, ALUControl codes and ImmSrc codes (I,S,B,J,U; 3 bits) in shared package riscv_pipe_pkg.
REQ-026 SHALL implement decode in one sub-module, decode_ctrl, covering opcode/funct3/funct7 -> control, ALUControl and ImmSrc.
REQ-027 SHALL keep the register file and immediate generator inline.

Verification
REQ-028 SHALL cover bypass: write x5=0x0000_00AA via W while InstrD=add x6,x5,x0 -> next cycle RD1_E=0x0000_00AA.
REQ-029 SHALL cover x0 protection: RegWriteW=1, RDW=0, ResultW=0xFFFF_FFFF, then read x0 -> RD1_E=0.
REQ-030 SHALL cover stall/flush: StallD=1 for 2 cycles -> E outputs frozen; then FlushE=1 with StallD=1 -> RegWriteE=0, ValidE=0, PCE=0.
REQ-031 SHALL cover immediates: lui x1,0x12345 -> Imm_Ext_E=0x1234_5000; jal with offset -4 -> Imm_Ext_E=0xFFFF_FFFC, JumpE=1, ResultSrcE=10.
REQ-032 SHALL cover async reset: rst low between clock edges while holding a valid instruction -> all E outputs 0 at once; x5 reads 0 after release.
REQ-033 SHALL cover invalid input: ValidD=0 with sw -> MemWriteE=0, ValidE=0, PCE=PCD.
